// File: rtl/tube_collision_score.sv
// -----------------------------------------------------------------------------
// tube_collision_score
//
// Game-logic back end for the scrolling-tube game. Consumes the three tube
// left-edge X positions and gap top-Y positions from the tube generator plus
// the bird's top-edge Y, detects bird/tube and bird/screen-edge collisions,
// counts passed tubes as the score and runs the game-state FSM
// (IDLE -> PLAYING -> HIT -> GAME_OVER -> PLAYING ...).
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   start_btn   in   start/flap button, synchronised level
//   bird_y      in   [10:0] bird top edge Y
//   tube_x      in   [10:0] x3 tube left edges
//   gap_y       in   [10:0] x3 gap top edges
//   game_rst    out  one-cycle pulse that reloads tube generator and bird
//   state       out  [1:0] 0=IDLE 1=PLAYING 2=HIT 3=GAME_OVER
//   collision   out  one-cycle pulse on PLAYING->HIT
//   score       out  [9:0] tubes passed this game, saturating at SCORE_MAX
//   high_score  out  [9:0] best score since reset (HIGH_SCORE_EN only)
//
// Configuration
//   HIGH_SCORE_EN  when defined, adds the high_score register and port.
//
// All outputs are registered: inputs sampled at edge N respond after edge N.
// -----------------------------------------------------------------------------
module tube_collision_score #(
  parameter int SCREEN_HEIGHT = 768,
  parameter int TUBE_WIDTH    = 120,
  parameter int GAP_HEIGHT    = 400,
  parameter int BIRD_X        = 200,
  parameter int BIRD_SIZE     = 40,
  parameter int DEATH_TICKS   = 50_000_000,
  parameter int SCORE_MAX     = 999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic [10:0] bird_y,
  input  logic [10:0] tube_x [2:0],
  input  logic [10:0] gap_y  [2:0],
  output logic        game_rst,
  output logic [1:0]  state,
  output logic        collision,
  output logic [9:0]  score
`ifdef HIGH_SCORE_EN
  ,
  output logic [9:0]  high_score
`endif
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAYING   = 2'd1,
    S_HIT       = 2'd2,
    S_GAME_OVER = 2'd3
  } state_e;

  // Death counter only needs to reach DEATH_TICKS-1; keep at least one bit.
  localparam int              CNT_W    = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEATH_TICKS - 1);

  // Geometry constants at 12 bits so that position + width never wraps.
  localparam logic [11:0] BIRD_LEFT  = 12'(BIRD_X);
  localparam logic [11:0] BIRD_RIGHT = 12'(BIRD_X + BIRD_SIZE);
  localparam logic [11:0] BIRD_SZ    = 12'(BIRD_SIZE);
  localparam logic [11:0] TUBE_W     = 12'(TUBE_WIDTH);
  localparam logic [11:0] GAP_H      = 12'(GAP_HEIGHT);
  localparam logic [11:0] SCR_H      = 12'(SCREEN_HEIGHT);
  localparam logic [10:0] SCORE_CAP  = 11'(SCORE_MAX);

  // Number of PLAYING cycles (starting with the game_rst cycle) in which
  // hit/pass evaluation is ignored while generator and bird reload.
  localparam logic [1:0] SETTLE_CYCLES = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic             btn_q;
  logic [2:0]       passed_q;
  logic [CNT_W-1:0] death_cnt_q;
  logic [1:0]       settle_q;
  logic [9:0]       score_q;
  logic             game_rst_q;
  logic             collision_q;

  // ---------------------------------------------------------------------------
  // Combinational geometry
  // ---------------------------------------------------------------------------
  logic [11:0] bird_top;
  logic [11:0] bird_bot;
  logic        edge_hit;
  logic [2:0]  overlap;
  logic [2:0]  pass;
  logic [2:0]  wrapped;
  logic        hit;
  logic        start_evt;
  logic [1:0]  pass_cnt;
  logic [10:0] score_sum;
  logic [9:0]  score_d;
  logic [2:0]  passed_d;

  // NOTE: every signal driven here gets a default assignment before any
  // conditional logic, so no path leaves a value unassigned and no latch forms.
  always_comb begin
    logic [11:0] tx_l;
    logic [11:0] tx_r;
    logic [11:0] gap_t;
    logic [11:0] gap_b;

    bird_top = {1'b0, bird_y};
    bird_bot = bird_top + BIRD_SZ;
    edge_hit = (bird_top == 12'd0) || (bird_bot >= SCR_H);
    overlap  = '0;
    pass     = '0;
    wrapped  = '0;
    tx_l     = '0;
    tx_r     = '0;
    gap_t    = '0;
    gap_b    = '0;

    for (int i = 0; i < 3; i++) begin
      tx_l  = {1'b0, tube_x[i]};
      tx_r  = tx_l + TUBE_W;
      gap_t = {1'b0, gap_y[i]};
      gap_b = gap_t + GAP_H;

      overlap[i] = (tx_l < BIRD_RIGHT) && (tx_r > BIRD_LEFT) &&
                   ((bird_top < gap_t) || (bird_bot > gap_b));
      // Tube fully left of the bird and not yet counted.
      pass[i]    = (tx_r <= BIRD_LEFT) && !passed_q[i];
      // Tube has scrolled off and been re-spawned on the right.
      wrapped[i] = (tx_l >= BIRD_RIGHT);
    end

    hit = edge_hit || (|overlap);
  end

  assign start_evt = start_btn && !btn_q;

  // Score accumulation, saturating at SCORE_MAX.
  always_comb begin
    pass_cnt  = {1'b0, pass[0]} + {1'b0, pass[1]} + {1'b0, pass[2]};
    score_sum = {1'b0, score_q} + {9'd0, pass_cnt};
    score_d   = (score_sum > SCORE_CAP) ? SCORE_CAP[9:0] : score_sum[9:0];
    // Set and clear conditions are mutually exclusive per tube.
    passed_d  = (passed_q | pass) & ~wrapped;
  end

  // ---------------------------------------------------------------------------
  // Game FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      btn_q       <= 1'b0;
      passed_q    <= '0;
      death_cnt_q <= '0;
      settle_q    <= '0;
      score_q     <= '0;
      game_rst_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      btn_q       <= start_btn;
      game_rst_q  <= 1'b0;
      collision_q <= 1'b0;

      case (state_q)
        S_IDLE, S_GAME_OVER: begin
          if (start_evt) begin
            state_q    <= S_PLAYING;
            game_rst_q <= 1'b1;
            score_q    <= '0;
            passed_q   <= '0;
            settle_q   <= SETTLE_CYCLES;
          end
        end

        S_PLAYING: begin
          if (settle_q != 2'd0) begin
            // Inputs still show stale positions; ignore them.
            settle_q <= settle_q - 2'd1;
          end else if (hit) begin
            // Hit wins over any simultaneous pass.
            state_q     <= S_HIT;
            collision_q <= 1'b1;
            death_cnt_q <= '0;
          end else begin
            score_q  <= score_d;
            passed_q <= passed_d;
          end
        end

        S_HIT: begin
          death_cnt_q <= death_cnt_q + CNT_W'(1);
          if (death_cnt_q == CNT_LAST) begin
            state_q <= S_GAME_OVER;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  logic [9:0] high_score_q;

  // Updated on HIT->GAME_OVER; untouched by game_rst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_score_q <= '0;
    end else if ((state_q == S_HIT) && (death_cnt_q == CNT_LAST) &&
                 (score_q > high_score_q)) begin
      high_score_q <= score_q;
    end
  end

  assign high_score = high_score_q;
`endif

  assign game_rst  = game_rst_q;
  assign state     = state_q;
  assign collision = collision_q;
  assign score     = score_q;

endmodule
